// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O controller: register map and bus width.
package board_io_pkg;

  localparam int REG_WIDTH = 32;

  localparam logic [2:0] REG_SW_STATE  = 3'd0;
  localparam logic [2:0] REG_BTN_STATE = 3'd1;
  localparam logic [2:0] REG_BTN_EVENT = 3'd2;
  localparam logic [2:0] REG_LED_ON    = 3'd3;
  localparam logic [2:0] REG_LED_PWM   = 3'd4;
  localparam logic [2:0] REG_PWM_DUTY  = 3'd5;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd6;
  localparam logic [2:0] REG_RESERVED  = 3'd7;

endpackage

// File: rtl/board_io_debounce.sv
// One-bit synchroniser and debouncer.
// Produces the stable level and a one-cycle pulse for the edge where stable rises.
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  logic        sync_q1;
  logic        sync_q2;
  logic [15:0] cnt_q;
  logic        take;

  // The stable value changes on the edge that would otherwise complete the count.
  assign take   = (sync_q2 != stable_o) && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
  assign rise_o = take && sync_q2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      cnt_q    <= '0;
      stable_o <= 1'b0;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
      if ((sync_q2 == stable_o) || take) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (take) begin
        stable_o <= sync_q2;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced switches/buttons, sticky button events with
// maskable interrupt, and static or PWM-driven LEDs behind a single-cycle register port.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int          N_SW            = 2,
  parameter int          N_BTN           = 5,
  parameter int          N_LED           = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          PWM_WIDTH       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SW-1:0]      sw_i,
  input  logic [N_BTN-1:0]     btn_i,
  output logic [N_LED-1:0]     led_o,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 rvalid_o,
  output logic                 irq_o
);

  localparam int N_IN = N_SW + N_BTN;

  logic [N_IN-1:0]      raw_all;
  logic [N_IN-1:0]      stable_all;
  logic [N_IN-1:0]      rise_all;
  logic [N_SW-1:0]      sw_state;
  logic [N_BTN-1:0]     btn_state;
  logic [N_BTN-1:0]     btn_rise;

  logic [N_BTN-1:0]     btn_event_q;
  logic [N_BTN-1:0]     irq_mask_q;
  logic [N_BTN-1:0]     event_clr;
  logic [N_LED-1:0]     led_on_q;
  logic [N_LED-1:0]     led_pwm_q;
  logic [N_LED-1:0]     led_next;
  logic [PWM_WIDTH-1:0] pwm_duty_q;
  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic                 pwm_on;
  logic                 wr_en;
  logic [REG_WIDTH-1:0] rd_val;

  logic unused_sw_rise;
  logic unused_wdata;

  assign raw_all = {btn_i, sw_i};

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    board_io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (raw_all[i]),
      .stable_o(stable_all[i]),
      .rise_o  (rise_all[i])
    );
  end

  assign sw_state       = stable_all[N_SW-1:0];
  assign btn_state      = stable_all[N_IN-1:N_SW];
  assign btn_rise       = rise_all[N_IN-1:N_SW];
  assign unused_sw_rise = ^rise_all[N_SW-1:0];
  assign unused_wdata   = ^wdata_i;

  assign wr_en     = req_i && we_i;
  assign event_clr = (wr_en && (addr_i == REG_BTN_EVENT)) ? wdata_i[N_BTN-1:0] : '0;

  always_comb begin
    rd_val = '0;
    case (addr_i)
      REG_SW_STATE:  rd_val[N_SW-1:0]      = sw_state;
      REG_BTN_STATE: rd_val[N_BTN-1:0]     = btn_state;
      REG_BTN_EVENT: rd_val[N_BTN-1:0]     = btn_event_q;
      REG_LED_ON:    rd_val[N_LED-1:0]     = led_on_q;
      REG_LED_PWM:   rd_val[N_LED-1:0]     = led_pwm_q;
      REG_PWM_DUTY:  rd_val[PWM_WIDTH-1:0] = pwm_duty_q;
      REG_IRQ_MASK:  rd_val[N_BTN-1:0]     = irq_mask_q;
      default:       rd_val                = '0;
    endcase
  end

  // A rise in the same cycle as a clear wins, so no press is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_event_q <= '0;
      irq_mask_q  <= '0;
      led_on_q    <= '0;
      led_pwm_q   <= '0;
      pwm_duty_q  <= '0;
    end else begin
      btn_event_q <= (btn_event_q & ~event_clr) | btn_rise;
      if (wr_en) begin
        case (addr_i)
          REG_LED_ON:   led_on_q   <= wdata_i[N_LED-1:0];
          REG_LED_PWM:  led_pwm_q  <= wdata_i[N_LED-1:0];
          REG_PWM_DUTY: pwm_duty_q <= wdata_i[PWM_WIDTH-1:0];
          REG_IRQ_MASK: irq_mask_q <= wdata_i[N_BTN-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i) ? rd_val : '0;
    end
  end

  assign pwm_on   = pwm_cnt_q < pwm_duty_q;
  assign led_next = (led_pwm_q & {N_LED{pwm_on}}) | (~led_pwm_q & led_on_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_cnt_q <= '0;
      led_o     <= '0;
      irq_o     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
      led_o     <= led_next;
      irq_o     <= |(btn_event_q & irq_mask_q);
    end
  end

endmodule
